// File: rtl/spram_bus_ctrl_if.sv
// CPU-side valid/ready memory bus toward the SPRAM controller.
interface spram_bus_ctrl_if;
  logic        mem_valid;
  logic        mem_ready;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid,
    output mem_addr,
    output mem_wdata,
    output mem_wstrb,
    input  mem_ready,
    input  mem_rdata
  );

  modport slave (
    input  mem_valid,
    input  mem_addr,
    input  mem_wdata,
    input  mem_wstrb,
    output mem_ready,
    output mem_rdata
  );
endinterface

// File: rtl/spram_bus_ctrl.sv
// Bridges a 32-bit valid/ready bus onto two 16-bit SB_SPRAM256KA macros (lo/hi halves),
// handling byte strobes, the registered read latency and SLEEP power sequencing.
module spram_bus_ctrl #(
  parameter int unsigned WAKE_CYCLES = 4
) (
  input  logic            clk,
  input  logic            resetn,
  spram_bus_ctrl_if.slave bus,
  input  logic            sleep_req,
  output logic            sleep_ack,
  output logic [13:0]     spram_addr,
  output logic [31:0]     spram_din,
  output logic [7:0]      spram_maskwren,
  output logic            spram_wren,
  output logic            spram_cs,
  output logic            spram_standby,
  output logic            spram_sleep,
  output logic            spram_poweroff,
  input  logic [31:0]     spram_dout
);

  localparam int unsigned CntW = (WAKE_CYCLES > 0) ? $clog2(WAKE_CYCLES + 1) : 1;
  localparam logic [CntW-1:0] WakeLoad = CntW'(WAKE_CYCLES);

  typedef enum logic [2:0] {
    StIdle,
    StRdWait,
    StRdCap,
    StDone,
    StSleep,
    StWake
  } state_e;

  state_e          state_q, state_d;
  logic            ready_q, ready_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            ack_q, ack_d;
  logic [13:0]     addr_q, addr_d;
  logic [31:0]     din_q, din_d;
  logic [7:0]      mask_q, mask_d;
  logic            wren_q, wren_d;
  logic            cs_q, cs_d;
  logic            sleep_q, sleep_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Byte lanes [1:0] of the address select nothing: the SPRAM pair is word-wide.
  logic unused_addr_bits;
  assign unused_addr_bits = ^bus.mem_addr[1:0];

  // Next-state and next-output decode for the access / power FSM.
  always_comb begin
    state_d = state_q;
    ready_d = ready_q;
    rdata_d = rdata_q;
    ack_d   = ack_q;
    addr_d  = addr_q;
    din_d   = din_q;
    mask_d  = mask_q;
    wren_d  = wren_q;
    cs_d    = cs_q;
    sleep_d = sleep_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        // A pending access wins over a sleep request.
        if (bus.mem_valid) begin
          cs_d   = 1'b1;
          addr_d = bus.mem_addr[15:2];
          wren_d = |bus.mem_wstrb;
          if (|bus.mem_wstrb) begin
            // SPRAM commits on the next edge, so the bus can be released right away.
            din_d   = bus.mem_wdata;
            mask_d  = {{2{bus.mem_wstrb[3]}}, {2{bus.mem_wstrb[2]}},
                       {2{bus.mem_wstrb[1]}}, {2{bus.mem_wstrb[0]}}};
            ready_d = 1'b1;
            state_d = StDone;
          end else begin
            mask_d  = '0;
            state_d = StRdWait;
          end
        end else if (sleep_req) begin
          sleep_d = 1'b1;
          ack_d   = 1'b1;
          state_d = StSleep;
        end
      end
      StRdWait: begin
        cs_d    = 1'b0;
        state_d = StRdCap;
      end
      StRdCap: begin
        rdata_d = spram_dout;
        ready_d = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        cs_d    = 1'b0;
        wren_d  = 1'b0;
        mask_d  = '0;
        ready_d = 1'b0;
        state_d = StIdle;
      end
      StSleep: begin
        cs_d = 1'b0;
        if (!sleep_req) begin
          sleep_d = 1'b0;
          if (WAKE_CYCLES == 0) begin
            ack_d   = 1'b0;
            state_d = StIdle;
          end else begin
            cnt_d   = WakeLoad;
            state_d = StWake;
          end
        end
      end
      StWake: begin
        if (cnt_q == '0) begin
          ack_d   = 1'b0;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and registered outputs; reset forces CS low asynchronously, aborting any access.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      ready_q <= 1'b0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      mask_q  <= '0;
      wren_q  <= 1'b0;
      cs_q    <= 1'b0;
      sleep_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= ready_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      mask_q  <= mask_d;
      wren_q  <= wren_d;
      cs_q    <= cs_d;
      sleep_q <= sleep_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.mem_ready   = ready_q;
  assign bus.mem_rdata   = rdata_q;
  assign sleep_ack       = ack_q;
  assign spram_addr      = addr_q;
  assign spram_din       = din_q;
  assign spram_maskwren  = mask_q;
  assign spram_wren      = wren_q;
  assign spram_cs        = cs_q;
  assign spram_sleep     = sleep_q;
  assign spram_standby   = 1'b0;
  assign spram_poweroff  = 1'b1;

endmodule

// File: tb/tb_spram_bus_ctrl.sv
// Randomized bench for spram_bus_ctrl: behavioural SPRAM pair plus a word-level golden memory.
module tb_spram_bus_ctrl;

  localparam int unsigned WakeCycles = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn;

  spram_bus_ctrl_if bus ();
  spram_bus_ctrl_if bus0 ();

  logic        sleep_req, sleep_ack;
  logic [13:0] spram_addr;
  logic [31:0] spram_din, spram_dout;
  logic [7:0]  spram_maskwren;
  logic        spram_wren, spram_cs, spram_standby, spram_sleep, spram_poweroff;

  logic        sleep_req0, sleep_ack0;
  logic [13:0] addr0;
  logic [31:0] din0;
  logic [7:0]  mask0;
  logic        wren0, cs0, standby0, sleep0, poweroff0;

  spram_bus_ctrl #(.WAKE_CYCLES(WakeCycles)) u_dut (
    .clk            (clk),
    .resetn         (resetn),
    .bus            (bus),
    .sleep_req      (sleep_req),
    .sleep_ack      (sleep_ack),
    .spram_addr     (spram_addr),
    .spram_din      (spram_din),
    .spram_maskwren (spram_maskwren),
    .spram_wren     (spram_wren),
    .spram_cs       (spram_cs),
    .spram_standby  (spram_standby),
    .spram_sleep    (spram_sleep),
    .spram_poweroff (spram_poweroff),
    .spram_dout     (spram_dout)
  );

  spram_bus_ctrl #(.WAKE_CYCLES(0)) u_dut0 (
    .clk            (clk),
    .resetn         (resetn),
    .bus            (bus0),
    .sleep_req      (sleep_req0),
    .sleep_ack      (sleep_ack0),
    .spram_addr     (addr0),
    .spram_din      (din0),
    .spram_maskwren (mask0),
    .spram_wren     (wren0),
    .spram_cs       (cs0),
    .spram_standby  (standby0),
    .spram_sleep    (sleep0),
    .spram_poweroff (poweroff0),
    .spram_dout     (32'h0)
  );

  // Behavioural SPRAM pair: nibble-masked write, registered read data.
  logic [31:0] sram [16384];
  always @(posedge clk) begin
    if (spram_cs && !spram_sleep && !spram_standby && spram_poweroff) begin
      if (spram_wren) begin
        for (int n = 0; n < 8; n++) begin
          if (spram_maskwren[n]) sram[spram_addr][4*n +: 4] <= spram_din[4*n +: 4];
        end
      end else begin
        spram_dout <= sram[spram_addr];
      end
    end
  end

  // Golden word memory built from byte-strobe rules.
  logic [31:0] gold [int];

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_write(input int w, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] v;
    v = gold.exists(w) ? gold[w] : 32'h0;
    for (int b = 0; b < 4; b++) if (s[b]) v[8*b +: 8] = d[8*b +: 8];
    gold[w] = v;
  endtask

  function automatic logic [7:0] exp_mask(input logic [3:0] s);
    logic [7:0] m;
    for (int b = 0; b < 4; b++) begin
      m[2*b]   = s[b];
      m[2*b+1] = s[b];
    end
    return m;
  endfunction

  // One access from IDLE; lat counts falling edges until mem_ready (0 = timeout).
  task automatic bus_access(input logic [15:0] a, input logic [31:0] wd, input logic [3:0] s,
                            output logic [31:0] rd, output int lat,
                            output logic [13:0] addr_s, output logic [7:0] mask_s,
                            output logic cs_s);
    bool_t: begin end
    bus.mem_addr  = a;
    bus.mem_wdata = wd;
    bus.mem_wstrb = s;
    bus.mem_valid = 1'b1;
    lat    = 0;
    rd     = '0;
    addr_s = '0;
    mask_s = '0;
    cs_s   = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) begin
        addr_s = spram_addr;
        mask_s = spram_maskwren;
        cs_s   = spram_cs;
      end
      if (bus.mem_ready) begin
        lat = i;
        rd  = bus.mem_rdata;
        break;
      end
    end
    bus.mem_valid = 1'b0;
    @(negedge clk);
    check_eq("ready_one_cycle", {31'b0, bus.mem_ready}, 32'h0);
  endtask

  logic [31:0] rd, wd;
  int          lat;
  logic [13:0] as;
  logic [7:0]  ms;
  logic        css;
  logic [3:0]  s;
  logic [15:0] a;
  int          w, cnt;
  logic        seen;
  int unsigned pool [8];
  int unsigned idx;

  initial begin
    resetn        = 1'b0;
    sleep_req     = 1'b0;
    sleep_req0    = 1'b0;
    bus.mem_valid = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.mem_wstrb = '0;
    bus0.mem_valid = 1'b0;
    bus0.mem_addr  = '0;
    bus0.mem_wdata = '0;
    bus0.mem_wstrb = '0;
    #1;
    check_eq("rst_ready", {31'b0, bus.mem_ready}, 32'h0);
    check_eq("rst_rdata", bus.mem_rdata, 32'h0);
    check_eq("rst_ack", {31'b0, sleep_ack}, 32'h0);
    check_eq("rst_addr", {18'b0, spram_addr}, 32'h0);
    check_eq("rst_din", spram_din, 32'h0);
    check_eq("rst_ctl", {26'b0, spram_maskwren == 8'h0, spram_wren, spram_cs, spram_standby,
                         spram_sleep, spram_poweroff}, 32'h21);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    // WAKE_CYCLES=0 instance: sleep, then back to IDLE one edge after the request falls.
    sleep_req0 = 1'b1;
    @(negedge clk);
    check_eq("w0_sleep", {30'b0, sleep0, sleep_ack0}, 32'h3);
    sleep_req0 = 1'b0;
    @(negedge clk);
    check_eq("w0_wake", {30'b0, sleep0, sleep_ack0}, 32'h0);
    bus0.mem_wstrb = 4'hF;
    bus0.mem_valid = 1'b1;
    @(negedge clk);
    check_eq("w0_ready", {31'b0, bus0.mem_ready}, 32'h1);
    bus0.mem_valid = 1'b0;
    @(negedge clk);

    // Basic write then read of the same word.
    bus_access(16'h0010, 32'hDEADBEEF, 4'hF, rd, lat, as, ms, css);
    model_write(4, 32'hDEADBEEF, 4'hF);
    check_eq("wr_lat", lat, 1);
    check_eq("wr_addr", {18'b0, as}, 32'h4);
    check_eq("wr_mask", {24'b0, ms}, 32'hFF);
    check_eq("wr_cs", {31'b0, css}, 32'h1);
    bus_access(16'h0010, 32'h0, 4'h0, rd, lat, as, ms, css);
    check_eq("rd_lat", lat, 3);
    check_eq("rd_data", rd, 32'hDEADBEEF);
    check_eq("rd_addr", {18'b0, as}, 32'h4);
    check_eq("rd_mask", {24'b0, ms}, 32'h0);

    // Partial-strobe merge; read data register is untouched by writes.
    bus_access(16'h0100, 32'h11223344, 4'hF, rd, lat, as, ms, css);
    model_write(16'h40, 32'h11223344, 4'hF);
    check_eq("rdata_hold", bus.mem_rdata, 32'hDEADBEEF);
    bus_access(16'h0100, 32'h0000AA00, 4'b0010, rd, lat, as, ms, css);
    model_write(16'h40, 32'h0000AA00, 4'b0010);
    check_eq("part_mask", {24'b0, ms}, 32'h0C);
    bus_access(16'h0100, 32'h0, 4'h0, rd, lat, as, ms, css);
    check_eq("part_data", rd, 32'h1122AA44);

    // Top word, with ignored low address bits.
    bus_access(16'hFFFC, 32'hCAFEF00D, 4'hF, rd, lat, as, ms, css);
    model_write(16'h3FFF, 32'hCAFEF00D, 4'hF);
    bus_access(16'hFFFF, 32'h0, 4'h0, rd, lat, as, ms, css);
    check_eq("top_addr", {18'b0, as}, 32'h3FFF);
    check_eq("top_data", rd, 32'hCAFEF00D);

    // Sleep requested together with a write: write first, then sleep.
    bus.mem_addr  = 16'h0200;
    bus.mem_wdata = 32'h5A5A1234;
    bus.mem_wstrb = 4'hF;
    bus.mem_valid = 1'b1;
    sleep_req     = 1'b1;
    @(negedge clk);
    check_eq("slp_wr_ready", {31'b0, bus.mem_ready}, 32'h1);
    bus.mem_valid = 1'b0;
    model_write(16'h80, 32'h5A5A1234, 4'hF);
    @(negedge clk);
    @(negedge clk);
    check_eq("slp_enter", {30'b0, spram_sleep, sleep_ack}, 32'h3);
    bus.mem_addr  = 16'h0200;
    bus.mem_wstrb = 4'h0;
    bus.mem_valid = 1'b1;
    seen = 1'b0;
    repeat (5) begin
      @(negedge clk);
      seen = seen | bus.mem_ready | spram_cs;
    end
    check_eq("slp_no_access", {31'b0, seen}, 32'h0);
    sleep_req = 1'b0;
    cnt = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (i == 1) check_eq("wake_state", {30'b0, spram_sleep, sleep_ack}, 32'h1);
      if (bus.mem_ready) begin
        cnt = i;
        rd  = bus.mem_rdata;
        break;
      end
    end
    bus.mem_valid = 1'b0;
    check_eq("wake_lat", cnt, WakeCycles + 5);
    check_eq("wake_data", rd, gold[16'h80]);
    @(negedge clk);
    check_eq("wake_ack", {31'b0, sleep_ack}, 32'h0);

    // Reset during RD_WAIT: CS drops at once, no ready, storage intact.
    bus.mem_addr  = 16'h0010;
    bus.mem_wstrb = 4'h0;
    bus.mem_valid = 1'b1;
    @(negedge clk);
    check_eq("abort_cs_before", {31'b0, spram_cs}, 32'h1);
    resetn = 1'b0;
    bus.mem_valid = 1'b0;
    #1;
    check_eq("abort_cs_async", {31'b0, spram_cs}, 32'h0);
    seen = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen = seen | bus.mem_ready;
    end
    resetn = 1'b1;
    repeat (3) begin
      @(negedge clk);
      seen = seen | bus.mem_ready;
    end
    check_eq("abort_no_ready", {31'b0, seen}, 32'h0);
    check_eq("abort_rdata_rst", bus.mem_rdata, 32'h0);
    bus_access(16'h0010, 32'h0, 4'h0, rd, lat, as, ms, css);
    check_eq("abort_reread", rd, 32'hDEADBEEF);

    // Randomized traffic over a small address pool.
    for (int i = 0; i < 8; i++) begin
      pool[i] = $urandom_range(0, 16383);
      wd = $urandom;
      bus_access({pool[i][13:0], 2'b00}, wd, 4'hF, rd, lat, as, ms, css);
      model_write(int'(pool[i]), wd, 4'hF);
      check_eq("rnd_fill_lat", lat, 1);
    end
    for (int k = 0; k < 80; k++) begin
      idx = $urandom_range(0, 7);
      w   = int'(pool[idx]);
      a   = {pool[idx][13:0], 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 1) == 0) begin
        bus_access(a, 32'h0, 4'h0, rd, lat, as, ms, css);
        check_eq("rnd_rd_lat", lat, 3);
        check_eq("rnd_rd_addr", {18'b0, as}, w);
        check_eq("rnd_rd_data", rd, gold[w]);
      end else begin
        s  = 4'($urandom_range(1, 15));
        wd = $urandom;
        bus_access(a, wd, s, rd, lat, as, ms, css);
        model_write(w, wd, s);
        check_eq("rnd_wr_lat", lat, 1);
        check_eq("rnd_wr_mask", {24'b0, ms}, {24'b0, exp_mask(s)});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
